// File: rtl/trace_fetch_scheduler.sv
// Shares the sample RAM read port between CPU loads and a background trace fetch
// that fills the back bank of a double-buffered line buffer read by the pixel pipeline.
module trace_fetch_scheduler #(
    parameter int                    SAMPLE_COUNT = 320,
    parameter int                    ADDR_WIDTH   = 12,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 12'h559
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic                  cpu_rd_en,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_rvalid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic [8:0]            pix_idx,
    output logic [7:0]            pix_height,
    output logic                  fetch_busy,
    output logic                  frame_missed
);

    localparam logic [8:0] LAST_IDX  = 9'(SAMPLE_COUNT - 1);
    localparam logic [8:0] PIX_LIMIT = 9'(SAMPLE_COUNT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [8:0]            idx_q, idx_d;
    logic                  front_sel_q, front_sel_d;
    logic                  front_valid_q, front_valid_d;
    logic                  frame_missed_q, frame_missed_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  tag_valid_q, tag_valid_d;
    logic                  tag_cpu_q, tag_cpu_d;
    logic [8:0]            tag_idx_q, tag_idx_d;
    logic [7:0]            pix_height_q, pix_height_d;
    logic                  fetch_issue;
    logic                  fetch_wr;
    logic [7:0]            front_rd;

    logic [7:0] bank0_mem [SAMPLE_COUNT];
    logic [7:0] bank1_mem [SAMPLE_COUNT];

    assign fetch_issue = (state_q == FETCH) && !cpu_rd_en;
    assign fetch_wr    = tag_valid_q && !tag_cpu_q;
    assign front_rd    = front_sel_q ? bank1_mem[pix_idx] : bank0_mem[pix_idx];

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        front_sel_d    = front_sel_q;
        front_valid_d  = front_valid_q;
        frame_missed_d = 1'b0;
        mem_addr_d     = mem_addr_q;
        tag_valid_d    = cpu_rd_en || fetch_issue;
        tag_cpu_d      = cpu_rd_en;
        tag_idx_d      = idx_q;
        pix_height_d   = (front_valid_q && (pix_idx < PIX_LIMIT)) ? front_rd : 8'd0;

        // The CPU always wins the port; the fetch only uses the leftover cycles.
        if (cpu_rd_en) begin
            mem_addr_d = cpu_addr;
        end else if (fetch_issue) begin
            mem_addr_d = BASE_ADDR + ADDR_WIDTH'(idx_q);
        end

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = FETCH;
                    idx_d   = 9'd0;
                end
            end
            FETCH: begin
                frame_missed_d = frame_start;
                if (fetch_issue) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end else begin
                        idx_d = idx_q + 9'd1;
                    end
                end
            end
            DRAIN: begin
                frame_missed_d = frame_start;
                state_d        = DONE;
            end
            DONE: begin
                if (frame_start) begin
                    front_sel_d   = !front_sel_q;
                    front_valid_d = 1'b1;
                    state_d       = FETCH;
                    idx_d         = 9'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            idx_q          <= 9'd0;
            front_sel_q    <= 1'b0;
            front_valid_q  <= 1'b0;
            frame_missed_q <= 1'b0;
            mem_addr_q     <= '0;
            tag_valid_q    <= 1'b0;
            tag_cpu_q      <= 1'b0;
            tag_idx_q      <= 9'd0;
            pix_height_q   <= 8'd0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            front_sel_q    <= front_sel_d;
            front_valid_q  <= front_valid_d;
            frame_missed_q <= frame_missed_d;
            mem_addr_q     <= mem_addr_d;
            tag_valid_q    <= tag_valid_d;
            tag_cpu_q      <= tag_cpu_d;
            tag_idx_q      <= tag_idx_d;
            pix_height_q   <= pix_height_d;
        end
    end

    // Fetch returns land in whichever bank is not currently being displayed.
    always_ff @(posedge clock) begin
        if (fetch_wr && !front_sel_q) begin
            bank1_mem[tag_idx_q] <= mem_rdata[11:4];
        end
        if (fetch_wr && front_sel_q) begin
            bank0_mem[tag_idx_q] <= mem_rdata[11:4];
        end
    end

    assign mem_addr     = mem_addr_d;
    assign cpu_rvalid   = tag_valid_q && tag_cpu_q;
    assign cpu_rdata    = (tag_valid_q && tag_cpu_q) ? mem_rdata : '0;
    assign pix_height   = pix_height_q;
    assign fetch_busy   = (state_q == FETCH) || (state_q == DRAIN);
    assign frame_missed = frame_missed_q;

endmodule

// File: tb/tb_trace_fetch_scheduler.sv
// Directed bench for trace_fetch_scheduler: burst timing, CPU priority, missed frames,
// bank swapping, pixel reads and mid-burst reset.
module tb_trace_fetch_scheduler;

    localparam logic [11:0] BASE = 12'h559;

    logic        clock;
    logic        reset;
    logic        frame_start;
    logic        cpu_rd_en;
    logic [11:0] cpu_addr;
    logic [31:0] cpu_rdata;
    logic        cpu_rvalid;
    logic [11:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [8:0]  pix_idx;
    logic [7:0]  pix_height;
    logic        fetch_busy;
    logic        frame_missed;

    logic [7:0]  ram_off;
    int          checks;
    int          errors;
    int          busy_ticks;
    int          missed_cnt;

    trace_fetch_scheduler dut (
        .clock        (clock),
        .reset        (reset),
        .frame_start  (frame_start),
        .cpu_rd_en    (cpu_rd_en),
        .cpu_addr     (cpu_addr),
        .cpu_rdata    (cpu_rdata),
        .cpu_rvalid   (cpu_rvalid),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .pix_idx      (pix_idx),
        .pix_height   (pix_height),
        .fetch_busy   (fetch_busy),
        .frame_missed (frame_missed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Sample RAM: word k holds (k + ram_off) << 4, one cycle read latency.
    always @(posedge clock) begin
        mem_rdata <= (32'(mem_addr) + 32'(ram_off)) << 4;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic fs, input logic rd, input logic [11:0] addr, input logic [8:0] pix);
        @(negedge clock);
        frame_start = fs;
        cpu_rd_en   = rd;
        cpu_addr    = addr;
        pix_idx     = pix;
        #1;
        if (fetch_busy) busy_ticks++;
        if (frame_missed) missed_cnt++;
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 12'h000, pix_idx);
    endtask

    task automatic pix_check(input string tag, input logic [8:0] idx, input logic [7:0] exp);
        tick(1'b0, 1'b0, 12'h000, idx);
        tick(1'b0, 1'b0, 12'h000, idx);
        chk(tag, 32'(pix_height), 32'(exp));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (fetch_busy && n < 1000) begin
            idle();
            n++;
        end
        chk(tag, 32'(fetch_busy), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_rvalid"}, 32'(cpu_rvalid), 32'd0);
        chk({tag, "_rdata"}, cpu_rdata, 32'd0);
        chk({tag, "_pix"}, 32'(pix_height), 32'd0);
        chk({tag, "_busy"}, 32'(fetch_busy), 32'd0);
        chk({tag, "_missed"}, 32'(frame_missed), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        busy_ticks  = 0;
        missed_cnt  = 0;
        ram_off     = 8'h00;
        reset       = 1'b1;
        frame_start = 1'b0;
        cpu_rd_en   = 1'b0;
        cpu_addr    = 12'h000;
        pix_idx     = 9'd0;

        // Reset state
        repeat (2) @(negedge clock);
        #1;
        chk_all_zero("reset");
        @(negedge clock);
        reset = 1'b0;

        // First burst from IDLE, no CPU traffic
        busy_ticks = 0;
        missed_cnt = 0;
        tick(1'b1, 1'b0, 12'h000, 9'd0);
        chk("t1_busy_at_start", 32'(fetch_busy), 32'd0);
        for (int k = 0; k < 320; k++) begin
            idle();
            chk("t1_addr", 32'(mem_addr), 32'(BASE + 12'(k)));
        end
        idle();
        chk("t1_drain_busy", 32'(fetch_busy), 32'd1);
        chk("t1_drain_addr_hold", 32'(mem_addr), 32'h698);
        idle();
        chk("t1_done_busy", 32'(fetch_busy), 32'd0);
        chk("t1_busy_cycles", 32'(busy_ticks), 32'd321);
        chk("t1_no_missed", 32'(missed_cnt), 32'd0);

        // Nothing displayed before the first swap
        pix_check("t5_preswap_5", 9'd5, 8'h00);
        pix_check("t5_preswap_100", 9'd100, 8'h00);

        // Second burst swaps; CPU steals 10 cycles mid-burst
        busy_ticks = 0;
        tick(1'b1, 1'b0, 12'h000, 9'd0);
        pix_check("t2_pix5", 9'd5, 8'h5E);
        pix_check("t2_pix0", 9'd0, 8'h59);
        pix_check("t2_pix319", 9'd319, 8'h98);
        pix_check("t5_pix320", 9'd320, 8'h00);
        repeat (42) idle();
        chk("t3_addr_before_cpu", 32'(mem_addr), 32'h58A);
        for (int j = 0; j < 10; j++) begin
            tick(1'b0, 1'b1, 12'h100, pix_idx);
            chk("t3_cpu_addr", 32'(mem_addr), 32'h100);
            if (j > 0) begin
                chk("t3_rvalid", 32'(cpu_rvalid), 32'd1);
                chk("t3_rdata", cpu_rdata, 32'h0000_1000);
            end else begin
                chk("t3_rvalid_first", 32'(cpu_rvalid), 32'd0);
            end
        end
        idle();
        chk("t3_rvalid_last", 32'(cpu_rvalid), 32'd1);
        chk("t3_rdata_last", cpu_rdata, 32'h0000_1000);
        chk("t3_addr_resume", 32'(mem_addr), 32'h58B);
        idle();
        chk("t3_rvalid_off", 32'(cpu_rvalid), 32'd0);
        chk("t3_addr_next", 32'(mem_addr), 32'h58C);
        wait_idle("t3_finish_timeout");
        chk("t3_busy_cycles", 32'(busy_ticks), 32'd331);

        // Third burst: frame_start 100 cycles in is missed
        ram_off    = 8'h20;
        busy_ticks = 0;
        missed_cnt = 0;
        tick(1'b1, 1'b0, 12'h000, 9'd5);
        repeat (99) idle();
        tick(1'b1, 1'b0, 12'h000, 9'd5);
        idle();
        chk("t4_missed_pulse", 32'(frame_missed), 32'd1);
        chk("t4_addr_unchanged", 32'(mem_addr), 32'h5BD);
        idle();
        chk("t4_missed_clear", 32'(frame_missed), 32'd0);
        pix_check("t4_no_swap_mid", 9'd5, 8'h5E);
        wait_idle("t4_finish_timeout");
        chk("t4_missed_count", 32'(missed_cnt), 32'd1);
        chk("t4_busy_cycles", 32'(busy_ticks), 32'd321);
        pix_check("t4_no_swap_done", 9'd5, 8'h5E);

        // Fourth burst: swap shows third burst data; frame_start in DRAIN is missed
        ram_off = 8'h40;
        tick(1'b1, 1'b0, 12'h000, 9'd5);
        pix_check("t4_swap_after_done", 9'd5, 8'h7E);
        repeat (318) idle();
        tick(1'b1, 1'b0, 12'h000, 9'd5);
        chk("drain_busy", 32'(fetch_busy), 32'd1);
        idle();
        chk("drain_missed", 32'(frame_missed), 32'd1);
        chk("drain_done_busy", 32'(fetch_busy), 32'd0);
        pix_check("drain_no_swap", 9'd5, 8'h7E);

        // Fifth burst, then reset mid-fetch
        tick(1'b1, 1'b0, 12'h000, 9'd5);
        pix_check("t6_pix5", 9'd5, 8'h9E);
        pix_check("t6_pix319", 9'd319, 8'hD8);
        repeat (20) idle();
        @(negedge clock);
        reset       = 1'b1;
        frame_start = 1'b0;
        cpu_rd_en   = 1'b0;
        #1;
        chk_all_zero("t6_reset");
        @(negedge clock);
        reset = 1'b0;
        pix_check("t6_post_reset_pix", 9'd5, 8'h00);
        tick(1'b1, 1'b0, 12'h000, 9'd5);
        chk("t6_idle_busy", 32'(fetch_busy), 32'd0);
        idle();
        chk("t6_restart_addr0", 32'(mem_addr), 32'h559);
        chk("t6_restart_busy", 32'(fetch_busy), 32'd1);
        idle();
        chk("t6_restart_addr1", 32'(mem_addr), 32'h55A);
        pix_check("t6_restart_no_swap", 9'd5, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
